// File: rtl/rcu_preg_release_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rcu_preg_release_pkg
// Description : Shared rename/commit constants and release-count encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rcu_preg_release_pkg;

    localparam int DEF_PREG_W    = 5;
    localparam int DEF_FL_SIZE   = 31;
    localparam int DEF_BUF_DEPTH = 4;

    // Number of indices moved in one cycle (enqueue, drain or pointer pulses)
    typedef enum logic [1:0] {
        REL_NONE = 2'd0,
        REL_ONE  = 2'd1,
        REL_TWO  = 2'd2
    } rel_cnt_e;

endpackage : rcu_preg_release_pkg
`default_nettype wire

// File: rtl/rcu_preg_release_buf.sv
`default_nettype none
// ============================================================================
// Module      : f2if2o_release_buf
// Description : Two-in/two-out circular queue of freed register indices.
// Revision    : 1.0 - initial release
// ============================================================================
module f2if2o_release_buf
    import rcu_preg_release_pkg::*;
#(
    parameter int DATA_W = DEF_PREG_W,
    parameter int DEPTH  = DEF_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  rel_cnt_e                   i_push_cnt,
    input  logic [DATA_W-1:0]          i_push_data0,
    input  logic [DATA_W-1:0]          i_push_data1,
    input  rel_cnt_e                   i_pop_cnt,
    output logic [DATA_W-1:0]          o_head_data0,
    output logic [DATA_W-1:0]          o_head_data1,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_head;
    logic [AW-1:0]     r_tail;
    logic [AW:0]       r_count;

    logic [AW-1:0]     w_tail_p1;
    logic [AW-1:0]     w_head_p1;

    // Pointer width equals log2(DEPTH), so plain addition wraps modulo DEPTH
    assign w_tail_p1 = r_tail + AW'(1);
    assign w_head_p1 = r_head + AW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + AW'(i_pop_cnt);
            r_tail  <= r_tail + AW'(i_push_cnt);
            r_count <= r_count + (AW+1)'(i_push_cnt) - (AW+1)'(i_pop_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && i_push_cnt != REL_NONE) begin
            r_mem[r_tail] <= i_push_data0;
        end
        if (!rst && i_push_cnt == REL_TWO) begin
            r_mem[w_tail_p1] <= i_push_data1;
        end
    end

    assign o_head_data0 = r_mem[r_head];
    assign o_head_data1 = r_mem[w_head_p1];
    assign o_count      = r_count;

endmodule : f2if2o_release_buf
`default_nettype wire

// File: rtl/rcu_preg_release.sv
`default_nettype none
// ============================================================================
// Module      : rcu_preg_release
// Description : Buffers freed physical registers from a 2-wide commit and
//               returns them to the freelist one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module rcu_preg_release
    import rcu_preg_release_pkg::*;
#(
    parameter int PREG_W    = DEF_PREG_W,
    parameter int FL_SIZE   = DEF_FL_SIZE,
    parameter int BUF_DEPTH = DEF_BUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              commit0_valid_i,
    input  logic              commit1_valid_i,
    input  logic              commit0_rd_used_i,
    input  logic              commit1_rd_used_i,
    input  logic [PREG_W-1:0] commit0_old_preg_i,
    input  logic [PREG_W-1:0] commit1_old_preg_i,
    output logic              commit_ready_o,
    input  logic              excep_i,
    input  logic [PREG_W:0]   fl_num_i,
    output logic              fl_wr_first_en_o,
    output logic              fl_wr_second_en_o,
    output logic [PREG_W-1:0] fl_wdata_first_o,
    output logic [PREG_W-1:0] fl_wdata_second_o,
    output logic              fl_rd_excep_first_en_o,
    output logic              fl_rd_excep_second_en_o,
    output logic              fl_excep_rst_o
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [CW-1:0]     w_count;
    logic [PREG_W-1:0] w_head0;
    logic [PREG_W-1:0] w_head1;
    logic              w_free0;
    logic              w_free1;
    logic [PREG_W-1:0] w_push_d0;
    logic [PREG_W:0]   w_room;
    rel_cnt_e          w_n_in;
    rel_cnt_e          w_n_out;

    // Ready depends only on the registered occupancy
    assign commit_ready_o = (w_count <= CW'(BUF_DEPTH - 2));

    assign w_free0 = commit0_valid_i & commit_ready_o & ~rst &
                     commit0_rd_used_i & (|commit0_old_preg_i);
    assign w_free1 = commit1_valid_i & commit_ready_o & ~rst &
                     commit1_rd_used_i & (|commit1_old_preg_i);

    // A lone freeing lane 1 takes the first slot
    assign w_push_d0 = w_free0 ? commit0_old_preg_i : commit1_old_preg_i;

    assign w_room = (fl_num_i >= (PREG_W+1)'(FL_SIZE)) ? '0
                  : (PREG_W+1)'(FL_SIZE) - fl_num_i;

    always_comb begin
        w_n_in = REL_NONE;
        if (w_free0 && w_free1) begin
            w_n_in = REL_TWO;
        end else if (w_free0 || w_free1) begin
            w_n_in = REL_ONE;
        end
    end

    always_comb begin
        w_n_out = REL_NONE;
        if (!rst) begin
            if (w_count >= CW'(2) && w_room >= (PREG_W+1)'(2)) begin
                w_n_out = REL_TWO;
            end else if (w_count >= CW'(1) && w_room >= (PREG_W+1)'(1)) begin
                w_n_out = REL_ONE;
            end
        end
    end

    f2if2o_release_buf #(
        .DATA_W (PREG_W),
        .DEPTH  (BUF_DEPTH)
    ) u_buf (
        .clk          (clk),
        .rst          (rst),
        .i_push_cnt   (w_n_in),
        .i_push_data0 (w_push_d0),
        .i_push_data1 (commit1_old_preg_i),
        .i_pop_cnt    (w_n_out),
        .o_head_data0 (w_head0),
        .o_head_data1 (w_head1),
        .o_count      (w_count)
    );

    assign fl_wr_first_en_o        = (w_n_out != REL_NONE);
    assign fl_wr_second_en_o       = (w_n_out == REL_TWO);
    assign fl_wdata_first_o        = fl_wr_first_en_o  ? w_head0 : '0;
    assign fl_wdata_second_o       = fl_wr_second_en_o ? w_head1 : '0;
    assign fl_rd_excep_first_en_o  = (w_n_in != REL_NONE);
    assign fl_rd_excep_second_en_o = (w_n_in == REL_TWO);
    assign fl_excep_rst_o          = excep_i;

endmodule : rcu_preg_release
`default_nettype wire

// File: tb/tb_rcu_preg_release.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcu_preg_release
// Description : Directed self-checking bench for rcu_preg_release.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcu_preg_release;

    localparam int PREG_W = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              c0_v, c1_v, c0_u, c1_u;
    logic [PREG_W-1:0] c0_p, c1_p;
    logic              ready;
    logic              excep;
    logic [PREG_W:0]   fl_num;
    logic              wr1, wr2;
    logic [PREG_W-1:0] wd1, wd2;
    logic              ex1, ex2;
    logic              exrst;

    int vectors    = 0;
    int miscompares = 0;

    rcu_preg_release dut (
        .clk                     (clk),
        .rst                     (rst),
        .commit0_valid_i         (c0_v),
        .commit1_valid_i         (c1_v),
        .commit0_rd_used_i       (c0_u),
        .commit1_rd_used_i       (c1_u),
        .commit0_old_preg_i      (c0_p),
        .commit1_old_preg_i      (c1_p),
        .commit_ready_o          (ready),
        .excep_i                 (excep),
        .fl_num_i                (fl_num),
        .fl_wr_first_en_o        (wr1),
        .fl_wr_second_en_o       (wr2),
        .fl_wdata_first_o        (wd1),
        .fl_wdata_second_o       (wd2),
        .fl_rd_excep_first_en_o  (ex1),
        .fl_rd_excep_second_en_o (ex2),
        .fl_excep_rst_o          (exrst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit(input logic v0, input logic [PREG_W-1:0] p0,
                          input logic v1, input logic [PREG_W-1:0] p1);
        c0_v = v0; c0_u = v0; c0_p = p0;
        c1_v = v1; c1_u = v1; c1_p = p1;
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic e1, input logic [PREG_W-1:0] d1,
                          input logic e2, input logic [PREG_W-1:0] d2);
        chk({tag, ".wr1"}, 32'(wr1), 32'(e1));
        chk({tag, ".wd1"}, 32'(wd1), 32'(d1));
        chk({tag, ".wr2"}, 32'(wr2), 32'(e2));
        chk({tag, ".wd2"}, 32'(wd2), 32'(d2));
    endtask

    initial begin
        rst = 1'b1; excep = 1'b0; fl_num = 6'd10;
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_wr("rst_hold", 1'b0, 5'd0, 1'b0, 5'd0);
        rst = 1'b0;
        tick();
        chk("rst_ready", 32'(ready), 32'd1);
        chk_wr("rst_idle", 1'b0, 5'd0, 1'b0, 5'd0);

        // Single commit on lane 0, pulse same cycle, write next cycle
        commit(1'b1, 5'd7, 1'b0, 5'd0);
        chk("c0.ex1", 32'(ex1), 32'd1);
        chk("c0.ex2", 32'(ex2), 32'd0);
        chk_wr("c0.nobypass", 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk_wr("c0.drain", 1'b1, 5'd7, 1'b0, 5'd0);
        tick();
        chk_wr("c0.empty", 1'b0, 5'd0, 1'b0, 5'd0);

        // Dual commit with empty freelist
        fl_num = 6'd0;
        commit(1'b1, 5'd3, 1'b1, 5'd9);
        chk("dual.ex1", 32'(ex1), 32'd1);
        chk("dual.ex2", 32'(ex2), 32'd1);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk_wr("dual.drain", 1'b1, 5'd3, 1'b1, 5'd9);
        tick();

        // Lane 0 frees p0: dropped, lane 1 compacts into first slot
        commit(1'b1, 5'd0, 1'b1, 5'd5);
        chk("p0.ex1", 32'(ex1), 32'd1);
        chk("p0.ex2", 32'(ex2), 32'd0);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk_wr("p0.drain", 1'b1, 5'd5, 1'b0, 5'd0);
        tick();

        // Lane without rd_used is not freed
        c0_v = 1'b1; c0_u = 1'b0; c0_p = 5'd17; #1;
        chk("norduse.ex1", 32'(ex1), 32'd0);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk_wr("norduse.drain", 1'b0, 5'd0, 1'b0, 5'd0);

        // Exception cycle commits are still released
        excep = 1'b1;
        commit(1'b1, 5'd12, 1'b0, 5'd0);
        chk("exc.rst", 32'(exrst), 32'd1);
        chk("exc.ex1", 32'(ex1), 32'd1);
        tick();
        excep = 1'b0;
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk("exc.rst_low", 32'(exrst), 32'd0);
        chk_wr("exc.drain", 1'b1, 5'd12, 1'b0, 5'd0);
        tick();

        // Freelist full: buffer fills, ready drops, then drains
        fl_num = 6'd31;
        commit(1'b1, 5'd1, 1'b1, 5'd2);
        tick();
        chk("full.ready2", 32'(ready), 32'd1);
        commit(1'b1, 5'd4, 1'b1, 5'd6);
        chk_wr("full.stall", 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk("full.ready4", 32'(ready), 32'd0);
        commit(1'b1, 5'd8, 1'b1, 5'd10);
        chk("full.noacc", 32'(ex1), 32'd0);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk("full.still", 32'(ready), 32'd0);
        fl_num = 6'd29; #1;
        chk_wr("full.drain1", 1'b1, 5'd1, 1'b1, 5'd2);
        tick();
        chk("full.ready_back", 32'(ready), 32'd1);
        chk_wr("full.drain2", 1'b1, 5'd4, 1'b1, 5'd6);
        tick();

        // Room for only one entry
        fl_num = 6'd31;
        commit(1'b1, 5'd20, 1'b1, 5'd21);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        fl_num = 6'd30; #1;
        chk_wr("room1.a", 1'b1, 5'd20, 1'b0, 5'd0);
        tick();
        chk_wr("room1.b", 1'b1, 5'd21, 1'b0, 5'd0);
        tick();
        chk_wr("room1.empty", 1'b0, 5'd0, 1'b0, 5'd0);

        // Reset with three entries buffered discards them
        fl_num = 6'd31;
        commit(1'b1, 5'd11, 1'b1, 5'd13);
        tick();
        commit(1'b1, 5'd14, 1'b0, 5'd0);
        tick();
        commit(1'b0, 5'd0, 1'b0, 5'd0);
        chk("mid.ready3", 32'(ready), 32'd0);
        rst = 1'b1;
        fl_num = 6'd0; #1;
        chk_wr("mid.rstcyc", 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        rst = 1'b0; #1;
        chk("mid.ready", 32'(ready), 32'd1);
        chk_wr("mid.after", 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        chk_wr("mid.after2", 1'b0, 5'd0, 1'b0, 5'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_rcu_preg_release
`default_nettype wire

// File: doc/rcu_preg_release.md
RCU_PREG_RELEASE -- requirements
Module: rcu_preg_release

Interface
REQ-001 SHALL have parameter PREG_W, default 5, meaning physical register index width; it matches the freelist data width.
REQ-002 SHALL have parameter FL_SIZE, default 31, meaning freelist capacity (p0 excluded).
REQ-003 SHALL have parameter BUF_DEPTH, default 4 (power of two, >=2), meaning release buffer entries.
REQ-004 SHALL have port clk, input, 1, clock.
REQ-005 SHALL have port rst, input, 1, reset (synchronous, active-high).
REQ-006 SHALL have ports commit0_valid_i / commit1_valid_i, input, 1 each, retiring instruction on lane 0/1 (lane 0 older).
REQ-007 SHALL have ports commit0_rd_used_i / commit1_rd_used_i, input, 1 each, instruction wrote a destination.
REQ-008 SHALL have ports commit0_old_preg_i / commit1_old_preg_i, input, PREG_W each, previous mapping of rd, to be freed.
REQ-009 SHALL have port commit_ready_o, output, 1, release unit can accept both lanes this cycle.
REQ-010 SHALL have port excep_i, input, 1, commit-stage exception/flush pulse.
REQ-011 SHALL have port fl_num_i, input, PREG_W+1, current freelist occupancy.
REQ-012 SHALL have ports fl_wr_first_en_o / fl_wr_second_en_o, output, 1 each, freelist write strobes.
REQ-013 SHALL have ports fl_wdata_first_o / fl_wdata_second_o, output, PREG_W each, freed indices.
REQ-014 SHALL have ports fl_rd_excep_first_en_o / fl_rd_excep_second_en_o, output, 1 each, advance freelist architectural read pointer.
REQ-015 SHALL have port fl_excep_rst_o, output, 1, rewind freelist speculative read pointer.

Function
REQ-016 A lane is accepted when commitN_valid_i & commit_ready_o; a lane is "freeing" when accepted & rd_used & old_preg != 0.
REQ-017 commit_ready_o SHALL be 1 exactly when buffer free slots >= 2, computed from registered count only (no combinational path from commit inputs).
REQ-018 Freeing lanes SHALL be compacted into the buffer in lane order: lane 0 first; a lone freeing lane 1 occupies the first slot.
REQ-019 Per cycle, architectural-pointer pulses SHALL be combinational from accepted lanes: number of accepting lanes with rd_used & old_preg != 0 (0,1,2) drives excep_first only, or both; a single pulse always uses fl_rd_excep_first_en_o.
REQ-020 Drain: n_out = min(buffer count, 2, FL_SIZE - fl_num_i); the oldest entry goes to first, the next to second; a single write always uses fl_wr_first_en_o; the second strobe is never asserted without the first.
REQ-021 Latency SHALL be one cycle: an index accepted in cycle T is written to the freelist no earlier than T+1; no bypass.
REQ-022 Enqueue and drain in the same cycle SHALL both occur; count_next = count + n_in - n_out, range 0..BUF_DEPTH.
REQ-023 Head/tail pointers SHALL be log2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH; the second slot is (ptr+1) mod BUF_DEPTH.
REQ-024 fl_excep_rst_o SHALL equal excep_i (combinational, same cycle).
REQ-025 Commits accepted in the excep_i cycle are older than the fault: they SHALL be enqueued and pulsed normally.
REQ-026 excep_i SHALL NOT flush the buffer; buffered indices belong to retired instructions.
REQ-027 When the freelist is full (fl_num_i == FL_SIZE), writes SHALL stall; buffer contents are retained and commit_ready_o drops once fewer than 2 slots remain free.
REQ-028 Wdata outputs SHALL be 0 when the corresponding strobe is low.
REQ-029 An accepted lane with old_preg == 0 and rd_used set SHALL be dropped: no enqueue and no pulse.

Reset
REQ-030 On rst the buffer SHALL be emptied: count = 0 and head = tail = 0.
REQ-031 On rst all strobes SHALL be 0 and commit_ready_o SHALL be 1 in the first cycle after rst deasserts.
REQ-032 A reset mid-operation SHALL discard buffered entries; no writes SHALL occur in the reset cycle.

Structure
REQ-033 PREG_W, FL_SIZE and the release-count encoding SHALL live in the shared rcu package.
REQ-034 The buffer SHALL be a sub-module f2if2o_release_buf: two-in two-out circular queue with count output, no ready logic inside.

Verification
REQ-035 Reset then single commit0 (rd_used=1, old_preg=7), fl_num=10 -> next cycle wr_first_en=1, wdata_first=7; excep_first pulse in the commit cycle.
REQ-036 Both lanes with old_preg 3 and 9, fl_num=0 -> one cycle later first=3, second=9; excep_first and excep_second both pulse.
REQ-037 Lane0 old_preg=0 (rd_used=1), lane1 old_preg=5 -> only wr_first with 5; one excep pulse.
REQ-038 Freelist full (fl_num=31), commit pairs each cycle -> buffer reaches 4; commit_ready_o goes low after 2 pairs; fl_num drops to 29 -> two writes next cycle, ready returns.
REQ-039 excep_i with commit0 old_preg=12 -> fl_excep_rst_o=1 same cycle; 12 still written next cycle; excep_first pulses.
REQ-040 rst asserted with 3 entries buffered -> no writes afterwards; count=0, ready=1.
